cache_axi_rd_bridge: RTL and testbench

CACHE_AXI_RD_BRIDGE -- requirements
Module: cache_axi_rd_bridge

---
 rtl/cache_axi_rd_bridge_pkg.sv | 19 +
 rtl/cache_axi_rd_bridge.sv | 121 ++++++++++++
 tb/tb_cache_axi_rd_bridge.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_axi_rd_bridge_pkg.sv
// Shared encodings for the cache-side AXI read bridge: request types, FSM states
// and the fixed AXI read-address attributes.
package cache_axi_rd_bridge_pkg;

    localparam logic [1:0] RD_WORD  = 2'd0;
    localparam logic [1:0] RD_LINE  = 2'd1;
    localparam logic [1:0] RD_DLINE = 2'd2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAr   = 2'd1,
        StR    = 2'd2
    } state_e;

    localparam logic [3:0] ARID           = 4'd1;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

endpackage

// File: rtl/cache_axi_rd_bridge.sv
// Single-outstanding AXI read bridge: turns word/line/double-line requests into one
// INCR burst and assembles the 32-bit beats into a 256-bit result register.
module cache_axi_rd_bridge
    import cache_axi_rd_bridge_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    input  logic         rd_req,
    input  logic [1:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic [255:0] ret_data,
    output logic         ret_half,
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic         arvalid,
    input  logic         arready,
    input  logic [3:0]   rid,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready
);

    state_e         state_q, state_d;
    logic [1:0]     type_q, type_d;
    logic [31:0]    addr_q, addr_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [255:0]   data_q, data_d;
    logic           ret_valid_q, ret_valid_d;
    logic           ret_half_q, ret_half_d;

    // Completion is purely by beat count, so the AXI status/tag inputs are not consumed.
    logic unused_axi;
    assign unused_axi = ^{rid, rresp, rlast};

    always_comb begin
        case (type_q)
            RD_WORD:  arlen = 8'd0;
            RD_DLINE: arlen = 8'd7;
            default:  arlen = 8'd3;
        endcase
        araddr = (type_q == RD_WORD) ? addr_q : {addr_q[31:4], 4'b0000};
    end

    assign arid      = ARID;
    assign arsize    = AXI_SIZE_4B;
    assign arburst   = AXI_BURST_INCR;
    assign rd_rdy    = (state_q == StIdle);
    assign arvalid   = (state_q == StAr);
    assign rready    = (state_q == StR);
    assign ret_valid = ret_valid_q;
    assign ret_half  = ret_half_q;
    assign ret_data  = data_q;

    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        ret_valid_d = 1'b0;
        ret_half_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rd_req) begin
                    type_d  = rd_type;
                    addr_d  = rd_addr;
                    cnt_d   = 3'd0;
                    data_d  = '0;
                    state_d = StAr;
                end
            end
            StAr: begin
                if (arready) begin
                    state_d = StR;
                end
            end
            StR: begin
                if (rvalid) begin
                    data_d[{cnt_q, 5'd0} +: 32] = rdata;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == arlen[2:0]) begin
                        state_d     = StIdle;
                        ret_valid_d = 1'b1;
                    end else if (type_q == RD_DLINE && cnt_q == 3'd3) begin
                        // Lower 128 bits are complete once beat 3 lands.
                        ret_half_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= StIdle;
            type_q      <= 2'd0;
            addr_q      <= 32'd0;
            cnt_q       <= 3'd0;
            data_q      <= '0;
            ret_valid_q <= 1'b0;
            ret_half_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            ret_valid_q <= ret_valid_d;
            ret_half_q  <= ret_half_d;
        end
    end

endmodule

// File: tb/tb_cache_axi_rd_bridge.sv
// Scoreboard bench for cache_axi_rd_bridge: directed requests push expected AR and
// return records; negedge monitors pop and compare whenever the DUT presents them.
module tb_cache_axi_rd_bridge;

    logic         clk;
    logic         resetn;
    logic         rd_req;
    logic [1:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic [255:0] ret_data;
    logic         ret_half;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;

    cache_axi_rd_bridge dut (
        .clk       (clk),
        .resetn    (resetn),
        .rd_req    (rd_req),
        .rd_type   (rd_type),
        .rd_addr   (rd_addr),
        .rd_rdy    (rd_rdy),
        .ret_valid (ret_valid),
        .ret_data  (ret_data),
        .ret_half  (ret_half),
        .arid      (arid),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .arvalid   (arvalid),
        .arready   (arready),
        .rid       (rid),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    typedef struct {
        logic         half;
        logic [255:0] data;
    } ret_t;

    ar_t         ar_exp_q[$];
    ret_t        ret_exp_q[$];
    logic [31:0] beat_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_valid_cyc = -1;
    int beats_done = 0;
    int ar_delay = 0;
    int rlast_at = -1;
    bit gap_en = 0;
    logic [1:0] rresp_val = 2'b00;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event seen or bound expired", name);
    endtask

    // AR monitor: every cycle arvalid is high the fields must match the pending entry.
    always @(negedge clk) begin
        if (arvalid === 1'b1) begin
            if (ar_exp_q.size() == 0) begin
                fail_now("unexpected_ar");
            end else begin
                chk("ar_fields", {araddr, arlen, arsize, arburst, arid},
                    {ar_exp_q[0].addr, ar_exp_q[0].len, 3'b010, 2'b01, 4'd1});
                if (arready === 1'b1) void'(ar_exp_q.pop_front());
            end
        end
    end

    // Return monitor.
    always @(negedge clk) begin
        ret_t e;
        if (ret_valid === 1'b1 && ret_half === 1'b1) fail_now("half_with_valid");
        if (ret_valid === 1'b1 || ret_half === 1'b1) begin
            if (ret_valid === 1'b1) last_valid_cyc = cyc;
            if (ret_exp_q.size() == 0) begin
                fail_now("unexpected_ret");
            end else begin
                e = ret_exp_q.pop_front();
                chk("ret_kind", {255'd0, ret_half}, {255'd0, e.half});
                chk("ret_data", ret_data, e.data);
            end
        end
    end

    // AXI slave: accepts AR after ar_delay cycles, then streams beats from beat_q.
    initial begin
        arready = 1'b0;
        rvalid  = 1'b0;
        rdata   = 32'd0;
        rresp   = 2'b00;
        rlast   = 1'b0;
        rid     = 4'd1;
        forever begin
            @(posedge clk);
            #1;
            if (arvalid === 1'b1 && resetn === 1'b1) begin
                int n;
                int b;
                int guard;
                bit gap;
                bit abort;
                bit acc;
                repeat (ar_delay) begin
                    @(posedge clk);
                    #1;
                end
                arready = 1'b1;
                n = int'(arlen) + 1;
                @(posedge clk);
                #1;
                arready = 1'b0;
                b = 0;
                guard = 0;
                gap = 0;
                abort = 0;
                while (b < n && !abort) begin
                    acc = 0;
                    if (gap_en && b[0] && !gap) begin
                        rvalid = 1'b0;
                        gap = 1;
                    end else begin
                        rvalid = 1'b1;
                        rdata  = (beat_q.size() > 0) ? beat_q[0] : 32'd0;
                        rresp  = rresp_val;
                        rlast  = (b == n - 1) || (b == rlast_at);
                    end
                    @(negedge clk);
                    if (resetn !== 1'b1) abort = 1;
                    else if (rvalid === 1'b1 && rready === 1'b1) acc = 1;
                    if (abort) rvalid = 1'b0;
                    @(posedge clk);
                    #1;
                    if (acc) begin
                        if (beat_q.size() > 0) void'(beat_q.pop_front());
                        b++;
                        beats_done++;
                        gap = 0;
                    end
                    guard++;
                    if (guard > 200) begin
                        fail_now("slave_beat_timeout");
                        abort = 1;
                    end
                end
                rvalid = 1'b0;
                rlast  = 1'b0;
                rresp  = 2'b00;
            end
        end
    end

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [1:0] t, input logic [31:0] a,
                         output int acc_at, output logic rv_at);
        int guard;
        bit done;
        guard = 0;
        done = 0;
        acc_at = -1;
        rv_at = 1'b0;
        rd_type = t;
        rd_addr = a;
        rd_req = 1'b1;
        while (!done && guard < 300) begin
            @(negedge clk);
            if (rd_rdy === 1'b1) begin
                done = 1;
                acc_at = cyc;
                rv_at = ret_valid;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        rd_req = 1'b0;
        if (!done) fail_now("accept_timeout");
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((ret_exp_q.size() != 0 || ar_exp_q.size() != 0) && guard < 400) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 400) fail_now("drain_timeout");
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_req(input logic [31:0] ar_addr, input logic [7:0] len,
                              input logic [255:0] data, input bit with_half);
        ret_t r;
        ar_t  x;
        x.addr = ar_addr;
        x.len  = len;
        ar_exp_q.push_back(x);
        if (with_half) begin
            r.half = 1'b1;
            r.data = {128'd0, data[127:0]};
            ret_exp_q.push_back(r);
        end
        r.half = 1'b0;
        r.data = data;
        ret_exp_q.push_back(r);
    endtask

    initial begin
        int   acc;
        logic rv;
        int   guard;
        resetn  = 1'b0;
        rd_req  = 1'b0;
        rd_type = 2'd0;
        rd_addr = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_rdy", {255'd0, rd_rdy}, 256'd1);
        chk("rst_strobes", {252'd0, ret_valid, ret_half, arvalid, rready}, 256'd0);
        chk("rst_ret_data", ret_data, 256'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Uncached word, slow arready.
        ar_delay = 3;
        beat_q.push_back(32'hDEADBEEF);
        expect_req(32'h1FC0_0104, 8'd0, {224'd0, 32'hDEADBEEF}, 0);
        issue(2'd0, 32'h1FC0_0104, acc, rv);
        drain();

        // Line at minimum latency.
        ar_delay = 0;
        beat_q = '{32'h11, 32'h22, 32'h33, 32'h44};
        expect_req(32'h8000_0020, 8'd3, {128'd0, 32'h44, 32'h33, 32'h22, 32'h11}, 0);
        issue(2'd1, 32'h8000_0028, acc, rv);
        drain();
        chk("line_latency", 256'(last_valid_cyc - acc), 256'd6);

        // Double line with rvalid gaps.
        gap_en = 1;
        beat_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        expect_req(32'h8000_0030, 8'd7, {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1}, 1);
        issue(2'd2, 32'h8000_0030, acc, rv);
        drain();
        gap_en = 0;

        // Type 3 behaves as a line; early rlast and SLVERR are ignored.
        rlast_at = 1;
        rresp_val = 2'b10;
        beat_q = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003, 32'hD0D0_0004};
        expect_req(32'h1234_5670, 8'd3,
                   {128'd0, 32'hD0D0_0004, 32'hC0C0_0003, 32'hB0B0_0002, 32'hA0A0_0001}, 0);
        issue(2'd3, 32'h1234_5678, acc, rv);
        drain();
        rlast_at = -1;
        rresp_val = 2'b00;

        // Back-to-back: second request accepted in the first ret_valid cycle.
        beat_q = '{32'hCAFE_0000, 32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003, 32'h55AA_55AA};
        expect_req(32'h0000_0040, 8'd3,
                   {128'd0, 32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000}, 0);
        expect_req(32'h0000_1004, 8'd0, {224'd0, 32'h55AA_55AA}, 0);
        issue(2'd1, 32'h0000_004C, acc, rv);
        issue(2'd0, 32'h0000_1004, acc, rv);
        chk("b2b_accept_in_ret_valid", {255'd0, rv}, 256'd1);
        @(negedge clk);
        chk("b2b_arvalid_next", {255'd0, arvalid}, 256'd1);
        @(posedge clk);
        #1;
        drain();

        // Reset during beat 5 of a double line.
        beats_done = 0;
        beat_q = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8};
        expect_req(32'h8000_0100, 8'd7, {32'h8, 32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1}, 1);
        issue(2'd2, 32'h8000_0100, acc, rv);
        guard = 0;
        while (beats_done < 4 && guard < 100) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (guard >= 100) fail_now("reset_setup_timeout");
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        ret_exp_q.delete();
        beat_q.delete();
        @(negedge clk);
        chk("midrst_rd_rdy", {255'd0, rd_rdy}, 256'd1);
        chk("midrst_strobes", {252'd0, ret_valid, ret_half, arvalid, rready}, 256'd0);
        chk("midrst_ret_data", ret_data, 256'd0);
        repeat (5) begin
            @(posedge clk);
            #1;
        end

        beat_q.push_back(32'h0BAD_F00D);
        expect_req(32'h0000_0008, 8'd0, {224'd0, 32'h0BAD_F00D}, 0);
        issue(2'd0, 32'h0000_0008, acc, rv);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
